// File: rtl/flash_write_sched.sv
// Flash write scheduler: splits a byte-range write into page bursts,
// triggers page programs and polls WIP between them.
module flash_write_sched #(
  parameter int PAGE_SIZE = 256,
  parameter int LEN_W     = 16,
  parameter int POLL_GAP  = 64,
  parameter int POLL_MAX  = 1024
) (
  input  logic             system_clk,
  input  logic             system_reset,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic [LEN_W-1:0] total_len,
  input  logic             mode,
  output logic             pp_key,
  output logic [31:0]      pp_addr,
  output logic [8:0]       pp_num,
  output logic             pp_mode,
  input  logic             pp_done,
  output logic             rdsr_req,
  input  logic             rdsr_done,
  input  logic [7:0]       rdsr_status,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] pages_done
);

  localparam int OFF_W  = $clog2(PAGE_SIZE);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int PCNT_W = $clog2(POLL_MAX + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(POLL_MAX);
  localparam logic [8:0]        PAGE_W9  = 9'(PAGE_SIZE);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT_PP,
    S_GAP,
    S_POLL,
    S_POLL_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t             state;
  logic [31:0]        addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [8:0]         chunk_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [PCNT_W-1:0]  poll_cnt;
  logic               pp_done_q;

  logic [8:0]         room;
  logic [8:0]         chunk_c;
  logic [31:0]        rem_ext;
  logic               pp_rise;
  logic               wip;
  logic               unused_status;

  assign wip           = rdsr_status[0];
  assign unused_status = ^rdsr_status[7:1];
  assign pp_rise       = pp_done & ~pp_done_q;

  // Burst size: remaining bytes clipped at the next page boundary
  always_comb begin
    room    = PAGE_W9 - 9'(addr_q[OFF_W-1:0]);
    rem_ext = 32'(rem_q);
    chunk_c = room;
    if (rem_ext < 32'(room)) begin
      chunk_c = rem_ext[8:0];
    end
  end

  // Sequencer: page bursts, WIP polling and registered host outputs
  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
      pp_done_q  <= 1'b0;
      pp_key     <= 1'b0;
      pp_addr    <= '0;
      pp_num     <= '0;
      pp_mode    <= 1'b0;
      rdsr_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pages_done <= '0;
    end else begin
      pp_done_q <= pp_done;
      pp_key    <= 1'b0;
      rdsr_req  <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_q     <= start_addr;
            rem_q      <= total_len;
            pp_mode    <= mode;
            err        <= 1'b0;
            pages_done <= '0;
            busy       <= 1'b1;
            state      <= S_CALC;
          end
        end
        S_CALC: begin
          if (rem_q == '0) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            pp_addr <= addr_q;
            pp_num  <= chunk_c;
            chunk_q <= chunk_c;
            pp_key  <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_PP;
        end
        S_WAIT_PP: begin
          if (pp_rise) begin
            gap_cnt  <= '0;
            poll_cnt <= '0;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            rdsr_req <= 1'b1;
            state    <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_POLL: begin
          poll_cnt <= poll_cnt + PCNT_W'(1);
          state    <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (rdsr_done) begin
            if (!wip) begin
              state <= S_NEXT;
            end else if (poll_cnt >= PCNT_MAX) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end
        S_NEXT: begin
          addr_q     <= addr_q + 32'(chunk_q);
          rem_q      <= rem_q - LEN_W'(chunk_q);
          pages_done <= pages_done + LEN_W'(1);
          state      <= S_CALC;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
